// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// Converts single commands from a valid/ready request channel into APB
// transfers and returns the result on a valid/ready response channel.
// Only one transfer is in flight at a time. An optional wait-state timeout
// aborts transfers whose slave never raises PREADY.
//
// Parameters
//   ADDR_W   width of cmd_addr / PADDR
//   TIMEOUT  number of ACCESS cycles with PREADY low before the transfer is
//            aborted with an error; 0 disables the timeout
//
// Ports
//   PCLK, PRESET      clock (rising edge), synchronous active-high reset
//   cmd_valid/ready   command handshake; cmd_write, cmd_addr, cmd_wdata
//   rsp_valid/ready   response handshake; rsp_rdata (0 for writes), rsp_err
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA     APB master outputs
//   PRDATA, PREADY, PSLVERR                  APB slave inputs
//
// State   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a command, cmd_ready=1
// SETUP   | APB setup phase, PSEL=1 PENABLE=0, one cycle
// ACCESS  | APB access phase, PSEL=1 PENABLE=1, waiting for PREADY/timeout
// RESP    | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module apb_cmd_master #(
   parameter int          ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic              PCLK,
   input  logic              PRESET,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,

   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int             CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit             TO_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt, wait_cnt_inc;
   logic             load_cmd;
   logic             psel_nxt, penable_nxt;
   logic             cmd_ready_nxt;
   logic             rsp_valid_nxt;
   logic [31:0]      rsp_rdata_nxt;
   logic             rsp_err_nxt;

   // Saturating increment of the wait-state counter.
   assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : (wait_cnt + CNT_ONE);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state     <= S_IDLE;
         wait_cnt  <= '0;
         cmd_ready <= 1'b1;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         cmd_ready <= cmd_ready_nxt;
         PSEL      <= psel_nxt;
         PENABLE   <= penable_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_rdata <= rsp_rdata_nxt;
         rsp_err   <= rsp_err_nxt;
         // The command registers drive the APB bus directly, so they stay
         // untouched for the whole SETUP/ACCESS window.
         if (load_cmd) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      load_cmd      = 1'b0;
      psel_nxt      = 1'b0;
      penable_nxt   = 1'b0;
      rsp_valid_nxt = 1'b0;
      rsp_rdata_nxt = rsp_rdata;
      rsp_err_nxt   = rsp_err;

      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_nxt    = S_SETUP;
               load_cmd     = 1'b1;
               wait_cnt_nxt = '0;
               psel_nxt     = 1'b1;
            end
         end

         S_SETUP: begin
            state_nxt   = S_ACCESS;
            psel_nxt    = 1'b1;
            penable_nxt = 1'b1;
         end

         S_ACCESS: begin
            if (PREADY) begin
               state_nxt     = S_RESP;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = PWRITE ? 32'h0 : PRDATA;
               rsp_err_nxt   = PSLVERR;
            end else begin
               wait_cnt_nxt = wait_cnt_inc;
               if (TO_EN && (wait_cnt_inc >= TO_VAL)) begin
                  // Abandon the transfer: bus released, error reported.
                  state_nxt     = S_RESP;
                  rsp_valid_nxt = 1'b1;
                  rsp_rdata_nxt = 32'h0;
                  rsp_err_nxt   = 1'b1;
               end else begin
                  psel_nxt    = 1'b1;
                  penable_nxt = 1'b1;
               end
            end
         end

         S_RESP: begin
            if (rsp_ready) begin
               state_nxt = S_IDLE;
            end else begin
               rsp_valid_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      // Registered copy of "next state is IDLE", so cmd_ready depends on
      // state alone and never on cmd_valid.
      cmd_ready_nxt = (state_nxt == S_IDLE);
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Self-checking bench for apb_cmd_master (TIMEOUT=8). A 64-word loopback
// APB slave (decoded on address bits 7:2) answers with a programmable number
// of wait states, an optional error flag and garbage on PRDATA/PSLVERR
// while PREADY is low. Expected responses come from a separate word array
// and the cycle arithmetic of the transfer (3 + wait states).
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PREADY, PSLVERR;

   int tests_run    = 0;
   int tests_failed = 0;
   int viol         = 0;

   // slave knobs
   int acc_cnt = 0;
   int wait_n  = 0;
   bit stuck   = 1'b0;
   bit slv_err = 1'b0;
   logic [31:0] smem [0:63] = '{default: 32'h0};
   logic [31:0] mdl  [0:63];

   always #5 PCLK = ~PCLK;

   apb_cmd_master #(.ADDR_W(32), .TIMEOUT(8)) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   // Loopback slave: garbage on data/error lines until PREADY rises.
   assign PREADY  = !stuck && (acc_cnt >= wait_n);
   assign PRDATA  = PREADY ? smem[PADDR[7:2]] : (32'hA5A5_5A5A ^ acc_cnt);
   assign PSLVERR = PREADY ? slv_err : 1'b1;

   always @(posedge PCLK) begin
      acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
      if (PSEL && PENABLE && PREADY && PWRITE) smem[PADDR[7:2]] <= PWDATA;
   end

   // Bus rule monitor.
   always @(negedge PCLK) begin
      if (PRESET === 1'b0) begin
         if (PENABLE === 1'b1 && PSEL !== 1'b1) viol <= viol + 1;
         if (PSEL === 1'b1 && (rsp_valid === 1'b1 || cmd_ready === 1'b1)) viol <= viol + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Runs one command from an IDLE sample point to the IDLE cycle after the
   // response handshake, returning what was observed.
   task automatic do_cmd(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input int waits, input bit stuck_in, input bit err_in,
                         input int bp, input bit hold,
                         output int lat, output int pen, output bit setup_ok,
                         output bit apb_stable, output bit busy_ok, output bit rsp_stable,
                         output bit idle_ok, output logic [31:0] rd, output bit er,
                         output bit timed_out);
      wait_n    = waits;
      stuck     = stuck_in;
      slv_err   = err_in;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      setup_ok  = (cmd_ready === 1'b1);
      tick();
      setup_ok = setup_ok && PSEL === 1'b1 && PENABLE === 1'b0 && PADDR === a &&
                 PWRITE === w && PWDATA === d && cmd_ready === 1'b0 && rsp_valid === 1'b0;
      if (hold) begin
         cmd_write = ~w;
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
      end else begin
         cmd_valid = 1'b0;
      end
      lat = 1; pen = 0; apb_stable = 1'b1; busy_ok = 1'b1; timed_out = 1'b0;
      while (rsp_valid !== 1'b1 && !timed_out) begin
         tick();
         lat++;
         if (rsp_valid !== 1'b1) begin
            if (PENABLE === 1'b1) pen++;
            if (PSEL !== 1'b1 || PENABLE !== 1'b1 || PADDR !== a || PWRITE !== w || PWDATA !== d)
               apb_stable = 1'b0;
         end
         if (cmd_ready !== 1'b0) busy_ok = 1'b0;
         if (lat > 60) timed_out = 1'b1;
      end
      if (PSEL !== 1'b0 || PENABLE !== 1'b0) apb_stable = 1'b0;
      rd = rsp_rdata;
      er = rsp_err;
      rsp_stable = 1'b1;
      for (int i = 0; i < bp; i++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er ||
             cmd_ready !== 1'b0 || PSEL !== 1'b0) rsp_stable = 1'b0;
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      idle_ok = rsp_valid === 1'b0 && cmd_ready === 1'b1 && PSEL === 1'b0 && PENABLE === 1'b0;
      stuck   = 1'b0;
      slv_err = 1'b0;
      wait_n  = 0;
   endtask

   task automatic test_reset();
      int lat, pen; bit s_ok, a_st, b_ok, r_st, i_ok, er, to; logic [31:0] rd, a, d;
      PRESET = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = $urandom; cmd_wdata = $urandom;
         tick();
         tests_run++;
         if ({cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 100000", {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err});
         end
         tests_run++;
         if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%h/%h want 0", PADDR, PWDATA, rsp_rdata);
         end
      end
      cmd_valid = 1'b0;
      PRESET = 1'b0;
      // first command issued in the very first cycle out of reset
      a = $urandom & 32'hFFFF_FFFC; d = $urandom;
      do_cmd(1'b1, a, d, 0, 1'b0, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      mdl[a[7:2]] = d;
      tests_run++;
      if (s_ok !== 1'b1 || lat !== 3) begin
         tests_failed++;
         $display("FAIL reset_first_cmd: setup_ok=%0b lat=%0d want 1/3", s_ok, lat);
      end
   endtask

   task automatic test_write_zero_wait();
      int lat, pen; bit s_ok, a_st, b_ok, r_st, i_ok, er, to; logic [31:0] rd;
      do_cmd(1'b1, 32'h4, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      mdl[1] = 32'hDEADBEEF;
      tests_run++;
      if (lat !== 3) begin tests_failed++; $display("FAIL wr0_latency: got %0d want 3", lat); end
      tests_run++;
      if ({s_ok, a_st, b_ok, i_ok, to} !== 5'b11110) begin
         tests_failed++; $display("FAIL wr0_phases: got %b want 11110", {s_ok, a_st, b_ok, i_ok, to});
      end
      tests_run++;
      if (pen !== 1) begin tests_failed++; $display("FAIL wr0_access_cycles: got %0d want 1", pen); end
      tests_run++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         tests_failed++; $display("FAIL wr0_rsp: got %h/%0b want 0/0", rd, er);
      end
   endtask

   task automatic test_read_loopback();
      int lat, pen; bit s_ok, a_st, b_ok, r_st, i_ok, er, to; logic [31:0] rd;
      do_cmd(1'b0, 32'h4, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      tests_run++;
      if (rd !== mdl[1] || er !== 1'b0) begin
         tests_failed++; $display("FAIL rd_loopback: got %h/%0b want %h/0", rd, er, mdl[1]);
      end
      tests_run++;
      if (lat !== 3 || i_ok !== 1'b1) begin
         tests_failed++; $display("FAIL rd_latency: got %0d idle=%0b want 3/1", lat, i_ok);
      end
   endtask

   task automatic test_wait_states();
      int lat, pen; bit s_ok, a_st, b_ok, r_st, i_ok, er, to; logic [31:0] rd;
      do_cmd(1'b1, 32'h10, 32'h12345678, 0, 1'b0, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      mdl[4] = 32'h12345678;
      do_cmd(1'b0, 32'h10, 32'h0, 5, 1'b0, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      tests_run++;
      if (pen !== 6) begin tests_failed++; $display("FAIL ws_penable_cycles: got %0d want 6", pen); end
      tests_run++;
      if (lat !== 8) begin tests_failed++; $display("FAIL ws_latency: got %0d want 8", lat); end
      tests_run++;
      if (a_st !== 1'b1) begin tests_failed++; $display("FAIL ws_apb_stable: got %0b want 1", a_st); end
      tests_run++;
      if (rd !== mdl[4] || er !== 1'b0) begin
         tests_failed++; $display("FAIL ws_rsp: got %h/%0b want %h/0", rd, er, mdl[4]);
      end
   endtask

   task automatic test_timeout();
      int lat, pen; bit s_ok, a_st, b_ok, r_st, i_ok, er, to; logic [31:0] rd;
      do_cmd(1'b0, 32'h4, 32'h0, 0, 1'b1, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      tests_run++;
      if (pen !== 8) begin tests_failed++; $display("FAIL to_access_cycles: got %0d want 8", pen); end
      tests_run++;
      if (lat !== 10) begin tests_failed++; $display("FAIL to_latency: got %0d want 10", lat); end
      tests_run++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         tests_failed++; $display("FAIL to_rsp: got %h/%0b want 0/1", rd, er);
      end
      tests_run++;
      if ({a_st, i_ok, to} !== 3'b110) begin
         tests_failed++; $display("FAIL to_bus_release: got %b want 110", {a_st, i_ok, to});
      end
      // aborted write must not reach the slave
      do_cmd(1'b1, 32'h24, 32'hCAFEF00D, 0, 1'b1, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      tests_run++;
      if (er !== 1'b1 || lat !== 10) begin
         tests_failed++; $display("FAIL to_write: got err=%0b lat=%0d want 1/10", er, lat);
      end
      do_cmd(1'b0, 32'h24, 32'h0, 1, 1'b0, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      tests_run++;
      if (rd !== mdl[9] || er !== 1'b0 || lat !== 4) begin
         tests_failed++; $display("FAIL to_recover: got %h/%0b/%0d want %h/0/4", rd, er, lat, mdl[9]);
      end
   endtask

   task automatic test_slverr_backpressure();
      int lat, pen; bit s_ok, a_st, b_ok, r_st, i_ok, er, to; logic [31:0] rd, a, d;
      a = $urandom & 32'hFFFF_FFFC; d = $urandom;
      do_cmd(1'b1, a, d, 0, 1'b0, 1'b1, 4, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      mdl[a[7:2]] = d;
      tests_run++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         tests_failed++; $display("FAIL se_write_rsp: got %h/%0b want 0/1", rd, er);
      end
      tests_run++;
      if ({r_st, b_ok, i_ok} !== 3'b111) begin
         tests_failed++; $display("FAIL se_backpressure: got %b want 111", {r_st, b_ok, i_ok});
      end
      do_cmd(1'b0, a, 32'h0, 2, 1'b0, 1'b1, 2, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      tests_run++;
      if (er !== 1'b1 || rd !== mdl[a[7:2]] || r_st !== 1'b1) begin
         tests_failed++; $display("FAIL se_read_rsp: got %h/%0b/%0b want %h/1/1", rd, er, r_st, mdl[a[7:2]]);
      end
   endtask

   task automatic test_reset_mid_access();
      int lat, pen; bit s_ok, a_st, b_ok, r_st, i_ok, er, to, seen; logic [31:0] rd, a, d;
      stuck = 1'b1;
      cmd_write = 1'b1; cmd_addr = 32'h38; cmd_wdata = 32'h0BAD_0BAD; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      tests_run++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
         tests_failed++; $display("FAIL rst_mid_in_access: got %0b%0b want 11", PSEL, PENABLE);
      end
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      stuck = 1'b0;
      tests_run++;
      if ({PSEL, PENABLE, rsp_valid, cmd_ready} !== 4'b0001) begin
         tests_failed++; $display("FAIL rst_mid_abort: got %b want 0001", {PSEL, PENABLE, rsp_valid, cmd_ready});
      end
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (rsp_valid !== 1'b0 || PSEL !== 1'b0) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_no_rsp: got activity=1 want 0"); end
      a = $urandom & 32'hFFFF_FFFC; d = $urandom;
      do_cmd(1'b1, a, d, 1, 1'b0, 1'b0, 0, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      mdl[a[7:2]] = d;
      do_cmd(1'b0, a, 32'h0, 0, 1'b0, 1'b0, 1, 1'b0, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
      tests_run++;
      if (rd !== d || er !== 1'b0 || lat !== 3) begin
         tests_failed++; $display("FAIL rst_mid_recover: got %h/%0b/%0d want %h/0/3", rd, er, lat, d);
      end
      tests_run++;
      if (mdl[14] !== smem[14]) begin
         tests_failed++; $display("FAIL rst_mid_no_write: slave word %h want %h", smem[14], mdl[14]);
      end
   endtask

   task automatic test_random();
      int lat, pen, waits, bp; bit s_ok, a_st, b_ok, r_st, i_ok, er, to, w, e, h;
      logic [31:0] rd, a, d, exp_rd;
      for (int n = 0; n < 30; n++) begin
         w = 1'($urandom_range(0, 1));
         a = $urandom & 32'hFFFF_FFFC;
         d = $urandom;
         waits = $urandom_range(0, 6);
         e = ($urandom_range(0, 3) == 0);
         bp = $urandom_range(0, 3);
         h = 1'($urandom_range(0, 1));
         exp_rd = w ? 32'h0 : mdl[a[7:2]];
         do_cmd(w, a, d, waits, 1'b0, e, bp, h, lat, pen, s_ok, a_st, b_ok, r_st, i_ok, rd, er, to);
         if (w) mdl[a[7:2]] = d;
         tests_run++;
         if (rd !== exp_rd || er !== e) begin
            tests_failed++;
            $display("FAIL rand_rsp[%0d]: got %h/%0b want %h/%0b (w=%0b a=%h)", n, rd, er, exp_rd, e, w, a);
         end
         tests_run++;
         if (lat !== 3 + waits || pen !== waits + 1) begin
            tests_failed++;
            $display("FAIL rand_timing[%0d]: got lat=%0d pen=%0d want %0d/%0d", n, lat, pen, 3 + waits, waits + 1);
         end
         tests_run++;
         if ({s_ok, a_st, b_ok, r_st, i_ok, to} !== 6'b111110) begin
            tests_failed++;
            $display("FAIL rand_handshake[%0d]: got %b want 111110", n, {s_ok, a_st, b_ok, r_st, i_ok, to});
         end
      end
   endtask

   task automatic test_protocol();
      tests_run++;
      if (viol !== 0) begin tests_failed++; $display("FAIL bus_rules: got %0d violations want 0", viol); end
   endtask

   initial begin
      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
      test_reset();
      test_write_zero_wait();
      test_read_loopback();
      test_wait_states();
      test_timeout();
      test_slverr_backpressure();
      test_reset_mid_access();
      test_random();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameter ADDR_W, default 32: width of cmd_addr and PADDR.
REQ-002 Parameter TIMEOUT, default 256: maximum number of ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 PCLK  in  1  clock; all logic is clocked on its rising edge.
REQ-005 PRESET  in  1  reset; synchronous, active-high.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_write  in  1  1 = write, 0 = read.
REQ-009 cmd_addr  in  ADDR_W  target address.
REQ-010 cmd_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  consumer accepts the response.
REQ-013 rsp_rdata  out  32  read data; 0 for writes.
REQ-014 rsp_err  out  1  PSLVERR was sampled high, or the timeout expired.
REQ-015 PSEL, PENABLE, PWRITE  out  1 each  APB control.
REQ-016 PADDR  out  ADDR_W  APB address.
REQ-017 PWDATA  out  32  APB write data.
REQ-018 PRDATA  in  32  APB read data.
REQ-019 PREADY  in  1  APB ready; tie high for slaves without wait states.
REQ-020 PSLVERR  in  1  APB error; tie low when the slave does not drive it.

Function
REQ-021 The block SHALL implement FSM states IDLE, SETUP, ACCESS and RESP, each with a registered output.
REQ-022 cmd_ready SHALL be 1 only in IDLE and is a function of state only; it does not depend on cmd_valid.
REQ-023 IDLE -> SETUP on cmd_valid & cmd_ready; cmd_write, cmd_addr and cmd_wdata SHALL be registered in the same edge.
REQ-024 In SETUP: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA from the registered command; SETUP lasts exactly 1 cycle, then -> ACCESS.
REQ-025 In ACCESS: PSEL=1, PENABLE=1, and PADDR/PWRITE/PWDATA SHALL be held stable.
REQ-026 In ACCESS, the transfer completes on the first cycle with PREADY=1.
- Capture PRDATA (reads only; 0 for writes) and PSLVERR into rsp_rdata/rsp_err.
- Next state RESP.
REQ-027 An ACCESS wait counter SHALL count cycles with PREADY=0.
- If TIMEOUT>0 and the counter reaches TIMEOUT: rsp_err=1, rsp_rdata=0, drop PSEL/PENABLE, next state RESP.
- The counter saturates and clears on entry to SETUP.
REQ-028 In RESP: rsp_valid=1, PSEL=0, PENABLE=0; rsp_rdata/rsp_err held stable until rsp_ready.
REQ-029 RESP -> IDLE on rsp_ready; rsp_valid SHALL fall the following cycle.
REQ-030 Minimum latency SHALL be as follows.
- Command accepted in cycle N: SETUP in N+1, ACCESS in N+2.
- With PREADY=1 in N+2, rsp_valid=1 in N+3.
- Next command accepted no earlier than the cycle after the rsp handshake.
REQ-031 PENABLE SHALL never be 1 while PSEL=0; PSEL SHALL never be 1 outside SETUP/ACCESS.
REQ-032 PRDATA/PSLVERR SHALL be ignored outside the completing ACCESS cycle.
REQ-033 cmd_valid asserted while not in IDLE SHALL have no effect; the upstream holds it until cmd_ready.

Reset
REQ-034 PRESET=1 at a clock edge SHALL force IDLE and set all of the following to 0:
- cmd_ready=1.
- PSEL, PENABLE, PWRITE, PADDR, PWDATA.
- rsp_valid, rsp_rdata, rsp_err.
- The wait counter.
REQ-035 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abort immediately, with no response generated.
REQ-036 Reset held for multiple cycles SHALL keep the block in IDLE; the first command is accepted in the first cycle after PRESET=0.

Verification
REQ-037 Write with zero wait states:
- Stimulus: cmd write addr 0x04, wdata 0xDEADBEEF, PREADY=1.
- Response: SETUP/ACCESS on consecutive cycles with PADDR=0x04; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
REQ-038 Read after write to a loopback slave:
- Stimulus: read addr 0x04.
- Response: rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-039 Wait states:
- Stimulus: PREADY low for 5 ACCESS cycles.
- Response: PENABLE=1 for 6 cycles, all APB outputs stable, response on PREADY rise with PRDATA=0x12345678 captured.
REQ-040 Timeout:
- Stimulus: TIMEOUT=8, PREADY stuck 0.
- Response: after 8 ACCESS cycles, PSEL drops, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-041 Slave error and response backpressure:
- Stimulus: PSLVERR=1 on completion; rsp_ready held 0 for 4 cycles.
- Response: rsp_err=1 held stable; cmd_ready=0 throughout; IDLE the cycle after rsp_ready=1.
REQ-042 Reset mid-ACCESS:
- Stimulus: PRESET=1 during ACCESS.
- Response: the next cycle shows PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1; a new command completes normally.
